readout_scheduler: RTL and testbench

//  Turns the single-cycle request pulses decoded from PC writes into framed, serialized readouts.

---
 rtl/readout_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_readout_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_scheduler.sv
`timescale 1ns/1ps
// readout_scheduler
//   Turns single-cycle readout request pulses into framed, serialized byte
//   streams towards the PC TX path. Pending requests are held as flags and
//   granted one frame at a time (trig > ch A > ch B, no preemption). A PC start
//   request is deferred while any readout is running or pending.
//
//   Optional feature: define READOUT_SCHED_CHECKSUM_EN to append an 8-bit
//   modulo-256 sum of the payload bytes after the last payload byte.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   rqst_ch1_i       pulse: read out channel A
//   rqst_ch2_i       pulse: read out channel B
//   rqst_trig_i      pulse: send trigger status
//   start_i          pulse: PC start request
//   trig_status_i    trigger status byte, sampled when its payload is loaded
//   ram_ch_sel_o     0 = channel A RAM, 1 = channel B RAM
//   ram_addr_o       RAM read address
//   ram_rd_o         RAM read strobe, data valid one cycle later
//   ram_data_i       RAM read data
//   tx_data_o        byte to PC
//   tx_valid_o       tx_data_o valid, held with data until accepted
//   tx_ready_i       sink ready; transfer on valid & ready
//   start_o          one-cycle start pulse to acquisition
//   busy_o           frame in progress or any request pending
module readout_scheduler #(
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned TX_DATA_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rqst_ch1_i,
  input  logic                      rqst_ch2_i,
  input  logic                      rqst_trig_i,
  input  logic                      start_i,
  input  logic [TX_DATA_WIDTH-1:0]  trig_status_i,
  output logic                      ram_ch_sel_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic                      ram_rd_o,
  input  logic [TX_DATA_WIDTH-1:0]  ram_data_i,
  output logic [TX_DATA_WIDTH-1:0]  tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic                      start_o,
  output logic                      busy_o
);

  localparam logic [TX_DATA_WIDTH-1:0] HDR_TRIG = TX_DATA_WIDTH'(8'hA3);
  localparam logic [TX_DATA_WIDTH-1:0] HDR_CHA  = TX_DATA_WIDTH'(8'hA1);
  localparam logic [TX_DATA_WIDTH-1:0] HDR_CHB  = TX_DATA_WIDTH'(8'hA2);

  // Request/grant bit positions: [0]=trig, [1]=ch A, [2]=ch B
  localparam int unsigned NREQ = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_STAT,
    S_RD,
    S_LAT,
    S_SEND
`ifdef READOUT_SCHED_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

  state_e                    state_q, state_d;
  logic [NREQ-1:0]           flags_q, flags_d;
  logic [NREQ-1:0]           grant_q, grant_d;
  logic [NREQ-1:0]           flag_clr;
  logic [NREQ-1:0]           rqst_vec;
  logic                      start_pend_q, start_pend_d;
  logic [RAM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [TX_DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      ram_rd_q, ram_rd_d;
  logic                      ram_ch_sel_q, ram_ch_sel_d;
  logic                      start_q, start_d;
  logic                      busy_q, busy_d;
  logic                      tx_accept;
  logic [TX_DATA_WIDTH-1:0]  payload_byte;

  assign rqst_vec     = {rqst_ch2_i, rqst_ch1_i, rqst_trig_i};
  assign tx_accept    = tx_valid_q & tx_ready_i;
  // Trigger frames carry the status byte, channel frames the RAM word
  assign payload_byte = (state_q == S_STAT) ? trig_status_i : ram_data_i;

`ifdef READOUT_SCHED_CHECKSUM_EN
  logic [TX_DATA_WIDTH-1:0] sum_q, sum_d;

  // Running payload sum; cleared while idle so every frame starts from zero
  always_comb begin
    sum_d = sum_q;
    if (state_q == S_IDLE) begin
      sum_d = '0;
    end else if (state_q == S_STAT || state_q == S_LAT) begin
      sum_d = sum_q + payload_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      flags_q      <= '0;
      grant_q      <= '0;
      start_pend_q <= 1'b0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      ram_rd_q     <= 1'b0;
      ram_ch_sel_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      grant_q      <= grant_d;
      start_pend_q <= start_pend_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      ram_rd_q     <= ram_rd_d;
      ram_ch_sel_q <= ram_ch_sel_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    start_pend_d = start_pend_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    ram_ch_sel_d = ram_ch_sel_q;
    ram_rd_d     = 1'b0;
    start_d      = 1'b0;
    flag_clr     = '0;

    case (state_q)
      S_IDLE: begin
        if (|flags_q) begin
          if (flags_q[0]) begin
            grant_d   = 3'b001;
            tx_data_d = HDR_TRIG;
          end else if (flags_q[1]) begin
            grant_d   = 3'b010;
            tx_data_d = HDR_CHA;
          end else begin
            grant_d   = 3'b100;
            tx_data_d = HDR_CHB;
          end
          ram_ch_sel_d = ~flags_q[0] & ~flags_q[1];
          tx_valid_d   = 1'b1;
          cnt_d        = '0;
          state_d      = S_HDR;
        end else if (start_pend_q) begin
          start_d      = 1'b1;
          start_pend_d = 1'b0;
        end
      end

      S_HDR: begin
        if (tx_accept) begin
          tx_valid_d = 1'b0;
          flag_clr   = grant_q;
          if (grant_q[0]) begin
            state_d = S_STAT;
          end else begin
            ram_rd_d = 1'b1;
            state_d  = S_RD;
          end
        end
      end

      S_STAT: begin
        tx_data_d  = payload_byte;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end

      S_RD: begin
        state_d = S_LAT;
      end

      S_LAT: begin
        tx_data_d  = payload_byte;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end

      S_SEND: begin
        if (tx_accept) begin
          tx_valid_d = 1'b0;
          if (!grant_q[0]) begin
            cnt_d = cnt_q + RAM_ADDR_WIDTH'(1);
          end
          if (!grant_q[0] && (cnt_q != '1)) begin
            ram_rd_d = 1'b1;
            state_d  = S_RD;
          end else begin
`ifdef READOUT_SCHED_CHECKSUM_EN
            tx_data_d  = sum_q;
            tx_valid_d = 1'b1;
            state_d    = S_CHK;
`else
            state_d    = S_IDLE;
`endif
          end
        end
      end

`ifdef READOUT_SCHED_CHECKSUM_EN
      S_CHK: begin
        if (tx_accept) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif

      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    // A new pulse beats the clear so a re-request yields one repeat frame
    flags_d = (flags_q & ~flag_clr) | rqst_vec;

    // A start colliding with activity or a new request is deferred
    if (start_i) begin
      if (!busy_q && !(|rqst_vec)) start_d      = 1'b1;
      else                         start_pend_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE) || (|flags_d);
  end

  assign ram_ch_sel_o = ram_ch_sel_q;
  assign ram_addr_o   = cnt_q;
  assign ram_rd_o     = ram_rd_q;
  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign start_o      = start_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_readout_scheduler.sv
`timescale 1ns/1ps
// Bench for readout_scheduler: reset, table-driven frame vectors, hand
// sequences for backpressure / start deferral / mid-frame reset, and
// randomized request sets with random backpressure against a frame model.
module tb_readout_scheduler;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned NSAMP = 1 << AW;
`ifdef READOUT_SCHED_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rqst_ch1_i, rqst_ch2_i, rqst_trig_i, start_i;
  logic [DW-1:0] trig_status_i;
  logic          ram_ch_sel_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_rd_o;
  logic [DW-1:0] ram_data_i;
  logic [DW-1:0] tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic          start_o;
  logic          busy_o;

  readout_scheduler #(.RAM_ADDR_WIDTH(AW), .TX_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .rqst_ch1_i(rqst_ch1_i), .rqst_ch2_i(rqst_ch2_i), .rqst_trig_i(rqst_trig_i),
    .start_i(start_i), .trig_status_i(trig_status_i),
    .ram_ch_sel_o(ram_ch_sel_o), .ram_addr_o(ram_addr_o), .ram_rd_o(ram_rd_o),
    .ram_data_i(ram_data_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .start_o(start_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;

  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW:0]   rd_q[$];
  logic [AW:0]   exp_rd_q[$];

  function automatic logic [DW-1:0] ram_val(logic ch, logic [AW-1:0] a);
    return {ch, 7'b0} + DW'(a) + 8'h10;
  endfunction

  // Synchronous RAM model with one cycle read latency
  always @(posedge clk) begin
    if (ram_rd_o) ram_data_i <= ram_val(ram_ch_sel_o, ram_addr_o);
    else          ram_data_i <= 8'hEE;
  end

  // Record accepted bytes, RAM reads and start pulses
  always @(negedge clk) begin
    if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
    if (ram_rd_o) rd_q.push_back({ram_ch_sel_o, ram_addr_o});
    if (start_o) start_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Frame model: header, payload, optional modulo-256 payload sum
  function automatic void add_frame(int kind, logic [DW-1:0] st);
    logic [DW-1:0] s = '0;
    logic [DW-1:0] b;
    case (kind)
      0:       exp_q.push_back(8'hA3);
      1:       exp_q.push_back(8'hA1);
      default: exp_q.push_back(8'hA2);
    endcase
    if (kind == 0) begin
      exp_q.push_back(st);
      s = st;
    end else begin
      for (int i = 0; i < NSAMP; i++) begin
        b = ram_val(kind == 2, AW'(i));
        exp_q.push_back(b);
        exp_rd_q.push_back({kind == 2, AW'(i)});
        s = s + b;
      end
    end
    if (CK == 1) exp_q.push_back(s);
  endfunction

  task automatic prep(input logic t, input logic a, input logic b, input logic [DW-1:0] st);
    got_q.delete(); exp_q.delete(); rd_q.delete(); exp_rd_q.delete();
    if (t) add_frame(0, st);
    if (a) add_frame(1, st);
    if (b) add_frame(2, st);
    trig_status_i = st;
  endtask

  task automatic wait_idle(input logic rnd);
    int n = 0;
    while (busy_o && n < 2000) begin
      tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
    end
    tx_ready_i = 1'b1;
    check("idle_timeout", int'(n < 2000), 1);
  endtask

  task automatic compare(input string tag, input int exp_len, input int exp_first);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    if (exp_len >= 0) check({tag, "_tbl_len"}, got_q.size(), exp_len);
    if (exp_first >= 0) check({tag, "_first"}, (got_q.size() > 0) ? int'(got_q[0]) : -1, exp_first);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? int'(got_q[i]) : -1, int'(exp_q[i]));
    check({tag, "_rd_len"}, rd_q.size(), exp_rd_q.size());
    for (int i = 0; i < exp_rd_q.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), (i < rd_q.size()) ? int'(rd_q[i]) : -1, int'(exp_rd_q[i]));
    check({tag, "_valid_end"}, tx_valid_o, 0);
  endtask

  task automatic run_txn(input string tag, input logic t, input logic a, input logic b,
                         input logic [DW-1:0] st, input logic rnd, input int exp_len,
                         input int exp_first);
    prep(t, a, b, st);
    rqst_trig_i = t; rqst_ch1_i = a; rqst_ch2_i = b;
    cyc();
    rqst_trig_i = 0; rqst_ch1_i = 0; rqst_ch2_i = 0;
    wait_idle(rnd);
    compare(tag, exp_len, exp_first);
  endtask

  typedef struct {
    logic          t, a, b;
    logic [DW-1:0] st;
    logic          rnd;
    int            exp_len;
    int            exp_first;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    rst = 1'b1; rqst_ch1_i = 0; rqst_ch2_i = 0; rqst_trig_i = 0; start_i = 0;
    trig_status_i = '0; tx_ready_i = 1'b1;

    vecs[0] = '{t:0, a:1, b:0, st:8'h00, rnd:0, exp_len:5 + CK,           exp_first:8'hA1};
    vecs[1] = '{t:1, a:1, b:1, st:8'h5A, rnd:0, exp_len:2 + CK + 2*(5+CK), exp_first:8'hA3};
    vecs[2] = '{t:0, a:0, b:1, st:8'h00, rnd:0, exp_len:5 + CK,           exp_first:8'hA2};
    vecs[3] = '{t:1, a:0, b:0, st:8'hC3, rnd:1, exp_len:2 + CK,           exp_first:8'hA3};
    vecs[4] = '{t:0, a:1, b:1, st:8'h00, rnd:1, exp_len:2*(5+CK),         exp_first:8'hA1};

    // Reset held 3 cycles, then 10 idle cycles
    repeat (3) cyc();
    check("rst_valid", tx_valid_o, 0);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;
    repeat (10) cyc();
    check("idle_valid", tx_valid_o, 0);
    check("idle_data", tx_data_o, 0);
    check("idle_rd", ram_rd_o, 0);
    check("idle_addr", ram_addr_o, 0);
    check("idle_sel", ram_ch_sel_o, 0);
    check("idle_start", start_o, 0);
    check("idle_busy", busy_o, 0);

    // Table-driven frames
    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].st,
              vecs[i].rnd, vecs[i].exp_len, vecs[i].exp_first);

    // Backpressure: hold the second payload byte for 5 cycles
    prep(0, 1, 0, 8'h00);
    rqst_ch1_i = 1; cyc(); rqst_ch1_i = 0;
    n = 0;
    while (!(tx_valid_o && tx_data_o == 8'h11) && n < 100) begin cyc(); n++; end
    tx_ready_i = 1'b0;
    check("stall_reach", int'(n < 100), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_valid", tx_valid_o, 1);
      check("stall_data", tx_data_o, 8'h11);
    end
    tx_ready_i = 1'b1;
    wait_idle(0);
    compare("stall", 5 + CK, 8'hA1);

    // Start during a ch B frame: deferred, collapsed to one pulse after the frame
    prep(0, 0, 1, 8'h00);
    start_cnt = 0;
    rqst_ch2_i = 1; cyc(); rqst_ch2_i = 0;
    repeat (3) cyc();
    start_i = 1; cyc(); start_i = 0;
    repeat (4) cyc();
    start_i = 1; cyc(); start_i = 0;
    check("start_defer", start_cnt, 0);
    wait_idle(0);
    check("start_at_fall", start_o, 0);
    cyc();
    check("start_pulse", start_o, 1);
    cyc();
    check("start_single", start_o, 0);
    check("start_count", start_cnt, 1);
    compare("startb", 5 + CK, 8'hA2);

    // Start while idle: pulse the next cycle
    start_cnt = 0;
    start_i = 1; cyc(); start_i = 0;
    check("start_idle", start_o, 1);
    cyc();
    check("start_idle_end", start_o, 0);
    check("start_idle_cnt", start_cnt, 1);

    // Start together with a request while idle: request wins
    prep(1, 0, 0, 8'h3C);
    start_cnt = 0;
    rqst_trig_i = 1; start_i = 1; cyc(); rqst_trig_i = 0; start_i = 0;
    check("coll_nostart", start_o, 0);
    check("coll_busy", busy_o, 1);
    wait_idle(0);
    check("coll_defer", start_cnt, 0);
    cyc();
    check("coll_pulse", start_o, 1);
    compare("coll", 2 + CK, 8'hA3);

    // Reset in the middle of the ch A payload with ch B pending
    got_q.delete();
    rqst_ch1_i = 1; rqst_ch2_i = 1; cyc(); rqst_ch1_i = 0; rqst_ch2_i = 0;
    n = 0;
    while (got_q.size() < 3 && n < 200) begin cyc(); n++; end
    check("mrst_reach", int'(n < 200), 1);
    rst = 1'b1;
    cyc();
    check("mrst_valid", tx_valid_o, 0);
    check("mrst_rd", ram_rd_o, 0);
    rst = 1'b0;
    n = got_q.size();
    repeat (40) cyc();
    check("mrst_nobytes", got_q.size(), n);
    check("mrst_busy", busy_o, 0);
    check("mrst_valid_end", tx_valid_o, 0);

    // Randomized request sets with random backpressure
    for (int r = 0; r < 12; r++) begin
      int k;
      k = int'($urandom_range(1, 7));
      run_txn($sformatf("rnd%0d", r), k[0], k[1], k[2], 8'($urandom), 1'b1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
